// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the multiply-accumulate sequencer: state
// encoding, default widths and a small width helper.
package mac_seq_ctrl_pkg;

  localparam int DEF_W           = 6;
  localparam int DEF_MULT_CYCLES = 6;
  localparam int DEF_ACC_W       = 16;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    ACCUM = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Width of a counter that must reach mult_cycles-1; never narrower than 1 bit.
  function automatic int wait_cnt_width(input int mult_cycles);
    if (mult_cycles > 1) begin
      return $clog2(mult_cycles);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, multiplier side-band and result stream of the
// multiply-accumulate sequencer. The slave view belongs to the sequencer,
// the master view to its environment (producer, consumer and multiplier).
interface mac_seq_ctrl_if
  import mac_seq_ctrl_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);

  // operand pair stream
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;

  // multiplier connection
  logic             mult_load;
  logic [W-1:0]     mult_a;
  logic [W-1:0]     mult_b;
  logic [2*W-1:0]   mult_product;

  // result stream
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mult_product, out_ready,
    output in_ready, mult_load, mult_a, mult_b,
    output out_valid, out_sum, out_ovf, out_count
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mult_product, out_ready,
    input  in_ready, mult_load, mult_a, mult_b,
    input  out_valid, out_sum, out_ovf, out_count
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Multiply-accumulate sequencer. Takes operand pairs, launches each on an
// external sequential multiplier with a one-cycle load strobe, waits a fixed
// latency, accumulates the product and, on the last term of a vector,
// presents the dot product until the consumer accepts it.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  mac_seq_ctrl_if.slave bus
);

  localparam int                WC_W      = wait_cnt_width(MULT_CYCLES);
  localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(MULT_CYCLES - 1);
  localparam int                PAD_W     = ACC_W + 1 - 2 * W;

  state_t            state;
  state_t            next_state;
  logic [WC_W-1:0]   wait_cnt;
  logic              last_q;
  logic              accept;
  logic [ACC_W:0]    sum_ext;

  // A pair is consumed only while the registered ready is high.
  assign accept = bus.in_valid & bus.in_ready;

  // Current state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = ACCUM;
        end else begin
          next_state = WAIT;
        end
      end
      ACCUM: begin
        if (last_q) begin
          next_state = OUT;
        end else begin
          next_state = IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = OUT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Zero-extended running sum plus product; the top bit is the carry-out.
  always_comb begin
    sum_ext = {1'b0, bus.out_sum} + {{PAD_W{1'b0}}, bus.mult_product};
  end

  // Handshake and strobe outputs follow the state being entered so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.in_ready  <= 1'b0;
      bus.mult_load <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.in_ready  <= (next_state == IDLE);
      bus.mult_load <= (next_state == LOAD);
      bus.out_valid <= (next_state == OUT);
    end
  end

  // Operand and last-flag capture; held for the whole multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mult_a <= {W{1'b0}};
      bus.mult_b <= {W{1'b0}};
      last_q     <= 1'b0;
    end else if (accept) begin
      bus.mult_a <= bus.in_a;
      bus.mult_b <= bus.in_b;
      last_q     <= bus.in_last;
    end else begin
      bus.mult_a <= bus.mult_a;
      bus.mult_b <= bus.mult_b;
      last_q     <= last_q;
    end
  end

  // Multiplier latency counter: cleared in LOAD, counts through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= {WC_W{1'b0}};
    end else if (state == LOAD) begin
      wait_cnt <= {WC_W{1'b0}};
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WC_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Accumulator, sticky carry and term count; cleared on result handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_sum   <= {ACC_W{1'b0}};
      bus.out_ovf   <= 1'b0;
      bus.out_count <= {CNT_W{1'b0}};
    end else if (state == ACCUM) begin
      bus.out_sum   <= sum_ext[ACC_W-1:0];
      bus.out_ovf   <= bus.out_ovf | sum_ext[ACC_W];
      bus.out_count <= bus.out_count + CNT_W'(1);
    end else if ((state == OUT) && bus.out_ready) begin
      bus.out_sum   <= {ACC_W{1'b0}};
      bus.out_ovf   <= 1'b0;
      bus.out_count <= {CNT_W{1'b0}};
    end else begin
      bus.out_sum   <= bus.out_sum;
      bus.out_ovf   <= bus.out_ovf;
      bus.out_count <= bus.out_count;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 6-cycle multiplier and
// a result scoreboard checked by an independent monitor.
module tb_mac_seq_ctrl;
  import mac_seq_ctrl_pkg::*;

  localparam int W     = 6;
  localparam int MC    = 6;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mac_seq_ctrl #(.W(W), .MULT_CYCLES(MC), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t e;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: product valid MC cycles after the load cycle, garbage before.
  int m_cnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0;
      bus.mult_product <= 12'hABC;
    end else if (bus.mult_load) begin
      m_cnt <= MC;
      bus.mult_product <= 12'hABC;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) bus.mult_product <= bus.mult_a * bus.mult_b;
    end
  end

  // Result monitor: compare each accepted result against the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_sum", bus.out_sum, e.sum);
        check("out_ovf", bus.out_ovf, e.ovf);
        check("out_count", bus.out_count, e.cnt);
      end
    end
  end

  // Load-strobe monitor: high cycles and distinct pulses.
  int   load_hi = 0;
  int   load_pulses = 0;
  logic load_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.mult_load) begin
      load_hi++;
      if (!load_prev) load_pulses++;
    end
    load_prev = bus.mult_load;
  end

  function automatic exp_t mk(input int s, input int o, input int c);
    exp_t r;
    r.sum = ACC_W'(s);
    r.ovf = o[0];
    r.cnt = CNT_W'(c);
    return r;
  endfunction

  // Present a pair; returns the cycle number of the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                      input bit hold, output int acc_cyc);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", 0, 1);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int vcyc);
    int t = 0;
    while (!bus.out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("out_valid_timeout", 0, 1);
    vcyc = cyc;
  endtask

  task automatic drain();
    int t = 0;
    while (bus.out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int k, k1, k2, k3, v;
    bus.in_valid  = 1'b0;
    bus.in_a      = 6'd0;
    bus.in_b      = 6'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_misc", {bus.mult_load, bus.mult_a, bus.mult_b, bus.out_ovf, bus.out_count}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);

    // single term, latency
    q.push_back(mk(361, 0, 1));
    send(6'd19, 6'd19, 1'b1, 1'b0, k);
    wait_valid(v);
    check("latency", v - k, 8);
    drain();

    // three terms with valid held
    q.push_back(mk(4011, 0, 3));
    send(6'd3, 6'd4, 1'b0, 1'b1, k1);
    send(6'd5, 6'd6, 1'b0, 1'b1, k2);
    send(6'd63, 6'd63, 1'b1, 1'b0, k3);
    check("term_period_1", k2 - k1, 9);
    check("term_period_2", k3 - k2, 9);
    wait_valid(v);
    drain();

    // 17 terms: accumulator wraps, sticky overflow
    q.push_back(mk(1937, 1, 17));
    for (int i = 0; i < 17; i++) begin
      send(6'd63, 6'd63, (i == 16), (i != 16), k);
    end
    wait_valid(v);
    drain();

    // backpressure in OUT; also shows overflow cleared for the new vector
    bus.out_ready = 1'b0;
    q.push_back(mk(6, 0, 1));
    send(6'd2, 6'd3, 1'b1, 1'b0, k);
    wait_valid(v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.out_sum, bus.out_ovf, bus.out_count},
            {1'b1, 1'b0, 16'd6, 1'b0, 8'd1});
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_idle", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});
    check("post_hs_acc", {bus.out_sum, bus.out_count}, 0);

    // reset during WAIT of the second term
    send(6'd5, 6'd5, 1'b0, 1'b0, k);
    send(6'd7, 6'd7, 1'b0, 1'b0, k);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_sum", bus.out_sum, 0);
    check("abort_misc", {bus.in_ready, bus.mult_load, bus.mult_a, bus.mult_b,
                         bus.out_valid, bus.out_ovf, bus.out_count}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_pending", q.size(), 0);
    q.push_back(mk(4, 0, 1));
    send(6'd2, 6'd2, 1'b1, 1'b0, k);
    wait_valid(v);
    drain();

    // zero operands, load-strobe shape
    load_hi = 0;
    load_pulses = 0;
    q.push_back(mk(0, 0, 2));
    send(6'd0, 6'd7, 1'b0, 1'b0, k);
    send(6'd0, 6'd0, 1'b1, 1'b0, k);
    wait_valid(v);
    drain();
    check("load_pulses", load_pulses, 2);
    check("load_high_cycles", load_hi, 2);

    @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
